// File: rtl/ixc_mev_sched.sv
// ixc_mev_sched: event-loop scheduler in front of the per-domain event clock generators.
// Bounds EVAL iterations, enforces a quiet settle window and runs the host stop handshake.
module ixc_mev_sched #(
  parameter int unsigned NCLK     = 4,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned LOOP_MAX = 16
) (
  input  logic            fclk,
  input  logic            rstN,
  input  logic            run,
  input  logic            stopReq,
  input  logic            clrOvf,
  input  logic [NCLK-1:0] active,
  input  logic [NCLK-1:0] busy,
  input  logic [NCLK-1:0] bwOn,
  output logic            eventOn,
  output logic            bClkHold,
  output logic [NCLK-1:0] hold,
  output logic            loop,
  output logic [7:0]      loopCnt,
  output logic            overflow,
  output logic            stopAck,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam logic [7:0] LOOP_MAX_C    = 8'(LOOP_MAX);
  localparam logic [7:0] LOOP_LAST_C   = 8'(LOOP_MAX - 1);
  localparam logic [3:0] SETTLE_INIT_C = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        settle_q, settle_d;
  logic              ovf_q, ovf_d;
  logic              ovf_set_s;
  logic              any_s, quiet_s;
  logic              bch_d;
  logic              eon_q, bch_q, loop_q, ack_q;
  logic [NCLK-1:0]   hold_q;

  // Next-state, iteration count, settle countdown and sticky overflow.
  always_comb begin
    any_s     = |active;
    quiet_s   = ~any_s & ~(|busy);
    state_d   = state_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    ovf_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stopReq) begin
          state_d = ST_HALT;
        end else if (run && !ovf_q) begin
          state_d = ST_EVAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (stopReq) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_INIT_C;
        end else if (any_s && (cnt_q == LOOP_LAST_C)) begin
          ovf_set_s = 1'b1;
          cnt_d     = LOOP_MAX_C;
          state_d   = ST_HALT;
        end else if (any_s) begin
          // Saturating: the count never wraps even if the limit check is bypassed.
          if (cnt_q < LOOP_MAX_C) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (quiet_s) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_INIT_C;
        end else begin
          state_d = ST_EVAL;
        end
      end
      ST_SETTLE: begin
        if (any_s && !stopReq) begin
          state_d = ST_EVAL;
        end else if ((settle_q == 4'd0) && stopReq) begin
          state_d = ST_HALT;
        end else if (settle_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_HALT: begin
        if (!stopReq && !ovf_q) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // A same-edge overflow set beats the host clear.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clrOvf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    bch_d = (state_d != ST_EVAL);
  end

  // State and registered outputs, all derived from the next-state values.
  always_ff @(posedge fclk) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      settle_q <= 4'd0;
      ovf_q    <= 1'b0;
      eon_q    <= 1'b0;
      bch_q    <= 1'b1;
      hold_q   <= {NCLK{1'b1}};
      loop_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      ovf_q    <= ovf_d;
      eon_q    <= ~bch_d;
      bch_q    <= bch_d;
      hold_q   <= {NCLK{bch_d}} | bwOn;
      loop_q   <= (state_d == ST_EVAL) && (cnt_d != 8'd0);
      ack_q    <= (state_d == ST_HALT);
    end
  end

  assign eventOn  = eon_q;
  assign bClkHold = bch_q;
  assign hold     = hold_q;
  assign loop     = loop_q;
  assign loopCnt  = cnt_q;
  assign overflow = ovf_q;
  assign stopAck  = ack_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ixc_mev_sched.sv
// Bench for ixc_mev_sched: hand-computed vector table, directed overflow/stop sequences,
// and randomized traffic against a rule-level reference model.
module tb_ixc_mev_sched;

  localparam int NCLK = 4;
  localparam int SETTLE = 2;
  localparam int LOOP_MAX = 16;

  logic fclk = 1'b0;
  logic rstN = 1'b0, run = 1'b0, stopReq = 1'b0, clrOvf = 1'b0;
  logic [3:0] active = 4'h0, busy = 4'h0, bwOn = 4'h0;
  logic eventOn, bClkHold, loop, overflow, stopAck;
  logic [3:0] hold;
  logic [7:0] loopCnt;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  ixc_mev_sched #(.NCLK(NCLK), .SETTLE(SETTLE), .LOOP_MAX(LOOP_MAX)) dut (
    .fclk(fclk), .rstN(rstN), .run(run), .stopReq(stopReq), .clrOvf(clrOvf),
    .active(active), .busy(busy), .bwOn(bwOn),
    .eventOn(eventOn), .bClkHold(bClkHold), .hold(hold), .loop(loop),
    .loopCnt(loopCnt), .overflow(overflow), .stopAck(stopAck), .state(state)
  );

  always #5 fclk = ~fclk;

  // Reference model: phase name plus counters, advanced by the written rules.
  int   m_st = 0, m_cnt = 0, m_set = 0;
  bit   m_ovf = 0, m_eon = 0, m_bch = 1, m_loop = 0, m_ack = 0;
  logic [3:0] m_hold = 4'hF;

  task automatic model_step();
    int  nst, ncnt, nset;
    bit  any, quiet, setovf;
    any = (active != 4'h0);
    quiet = (active == 4'h0) && (busy == 4'h0);
    if (!rstN) begin
      m_st = 0; m_cnt = 0; m_set = 0; m_ovf = 0;
      m_eon = 0; m_bch = 1; m_hold = 4'hF; m_loop = 0; m_ack = 0;
      return;
    end
    nst = m_st; ncnt = m_cnt; nset = m_set; setovf = 0;
    if (m_st == 0) begin
      if (stopReq) nst = 3;
      else if (run && !m_ovf) nst = 1;
    end else if (m_st == 1) begin
      if (stopReq) begin nst = 2; nset = SETTLE - 1; end
      else if (any && m_cnt == LOOP_MAX - 1) begin setovf = 1; ncnt = LOOP_MAX; nst = 3; end
      else if (any) ncnt = (m_cnt + 1 > LOOP_MAX) ? LOOP_MAX : m_cnt + 1;
      else if (quiet) begin nst = 2; nset = SETTLE - 1; end
    end else if (m_st == 2) begin
      if (any && !stopReq) nst = 1;
      else if (m_set == 0 && stopReq) nst = 3;
      else if (m_set == 0) begin nst = 0; ncnt = 0; end
      else nset = m_set - 1;
    end else begin
      if (!stopReq && !m_ovf) begin nst = 0; ncnt = 0; end
    end
    if (setovf) m_ovf = 1;
    else if (clrOvf) m_ovf = 0;
    m_st = nst; m_cnt = ncnt; m_set = nset;
    m_eon = (nst == 1);
    m_bch = !m_eon;
    m_hold = {4{m_bch}} | bwOn;
    m_loop = (nst == 1) && (ncnt > 0);
    m_ack = (nst == 3);
  endtask

  task automatic step();
    @(posedge fclk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string nm);
    total++;
    if (state !== 2'(m_st) || loopCnt !== 8'(m_cnt) || eventOn !== m_eon || bClkHold !== m_bch ||
        hold !== m_hold || loop !== m_loop || overflow !== m_ovf || stopAck !== m_ack) begin
      bad++;
      $display("FAIL %s: got st=%0d cnt=%0d eon=%0d bch=%0d hold=%h loop=%0d ovf=%0d ack=%0d want st=%0d cnt=%0d eon=%0d bch=%0d hold=%h loop=%0d ovf=%0d ack=%0d",
               nm, state, loopCnt, eventOn, bClkHold, hold, loop, overflow, stopAck,
               m_st, m_cnt, m_eon, m_bch, m_hold, m_loop, m_ovf, m_ack);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  typedef struct {
    logic r, rn, sp, cl;
    logic [3:0] act, bsy, bw;
    logic [1:0] st;
    logic [7:0] cnt;
    logic eon;
    logic [3:0] hl;
    logic lp, ovf, ack;
  } vec_t;

  vec_t tab[20];

  function automatic vec_t mk(logic r, logic rn, logic sp, logic cl, logic [3:0] act,
                              logic [3:0] bsy, logic [3:0] bw, logic [1:0] st, logic [7:0] cnt,
                              logic eon, logic [3:0] hl, logic lp, logic ovf, logic ack);
    vec_t v;
    v.r = r; v.rn = rn; v.sp = sp; v.cl = cl; v.act = act; v.bsy = bsy; v.bw = bw;
    v.st = st; v.cnt = cnt; v.eon = eon; v.hl = hl; v.lp = lp; v.ovf = ovf; v.ack = ack;
    return v;
  endfunction

  initial begin
    //           rstN run stp clr act    bsy    bw    | st    cnt    eon  hold   loop ovf  ack
    tab[0]  = mk(1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[1]  = mk(1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[2]  = mk(1'b1,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[3]  = mk(1'b1,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[4]  = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd1,8'd0,1'b1,4'h0,1'b0,1'b0,1'b0);
    tab[5]  = mk(1'b1,1'b1,1'b0,1'b0,4'h1,4'h0,4'h0, 2'd1,8'd1,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[6]  = mk(1'b1,1'b1,1'b0,1'b0,4'h1,4'h0,4'h0, 2'd1,8'd2,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[7]  = mk(1'b1,1'b1,1'b0,1'b0,4'h1,4'h0,4'h0, 2'd1,8'd3,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[8]  = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd2,8'd3,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[9]  = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd2,8'd3,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[10] = mk(1'b1,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[11] = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd1,8'd0,1'b1,4'h0,1'b0,1'b0,1'b0);
    tab[12] = mk(1'b1,1'b1,1'b0,1'b0,4'h8,4'h0,4'h0, 2'd1,8'd1,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[13] = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd2,8'd1,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[14] = mk(1'b1,1'b1,1'b0,1'b0,4'h8,4'h0,4'h0, 2'd1,8'd1,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[15] = mk(1'b1,1'b1,1'b0,1'b0,4'h8,4'h0,4'h0, 2'd1,8'd2,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[16] = mk(1'b1,1'b1,1'b0,1'b0,4'h0,4'h1,4'h4, 2'd1,8'd2,1'b1,4'h4,1'b1,1'b0,1'b0);
    tab[17] = mk(1'b1,1'b1,1'b0,1'b0,4'h1,4'h0,4'h0, 2'd1,8'd3,1'b1,4'h0,1'b1,1'b0,1'b0);
    tab[18] = mk(1'b0,1'b1,1'b0,1'b0,4'h1,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);
    tab[19] = mk(1'b1,1'b0,1'b0,1'b0,4'h0,4'h0,4'h0, 2'd0,8'd0,1'b0,4'hF,1'b0,1'b0,1'b0);

    #1;
    for (int i = 0; i < 20; i++) begin
      rstN = tab[i].r; run = tab[i].rn; stopReq = tab[i].sp; clrOvf = tab[i].cl;
      active = tab[i].act; busy = tab[i].bsy; bwOn = tab[i].bw;
      step();
      total++;
      if (state !== tab[i].st || loopCnt !== tab[i].cnt || eventOn !== tab[i].eon ||
          bClkHold !== ~tab[i].eon || hold !== tab[i].hl || loop !== tab[i].lp ||
          overflow !== tab[i].ovf || stopAck !== tab[i].ack) begin
        bad++;
        $display("FAIL vec%0d: got st=%0d cnt=%0d eon=%0d bch=%0d hold=%h loop=%0d ovf=%0d ack=%0d want st=%0d cnt=%0d eon=%0d hold=%h loop=%0d ovf=%0d ack=%0d",
                 i, state, loopCnt, eventOn, bClkHold, hold, loop, overflow, stopAck,
                 tab[i].st, tab[i].cnt, tab[i].eon, tab[i].hl, tab[i].lp, tab[i].ovf, tab[i].ack);
      end
    end

    // Overflow: continuous activity hits the iteration limit and parks in HALT.
    run = 1'b1; active = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      check_model("ovf_run");
    end
    chk("ovf_state", int'(state), 3);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_ack", int'(stopAck), 1);
    chk("ovf_cnt", int'(loopCnt), LOOP_MAX);
    run = 1'b0; active = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("ovf_park");
    end
    chk("ovf_still_halt", int'(state), 3);
    clrOvf = 1'b1;
    step();
    clrOvf = 1'b0;
    chk("clr_ovf_flag", int'(overflow), 0);
    chk("clr_ovf_state", int'(state), 3);
    step();
    chk("clr_exit_state", int'(state), 0);
    chk("clr_exit_ack", int'(stopAck), 0);
    chk("clr_exit_cnt", int'(loopCnt), 0);

    // Stop handshake: drain through SETTLE while activity toggles.
    run = 1'b1;
    step();
    active = 4'h1;
    step();
    step();
    chk("stop_pre_cnt", int'(loopCnt), 2);
    stopReq = 1'b1; active = 4'h1;
    step();
    check_model("stop_settle1");
    chk("stop_settle_eon", int'(eventOn), 0);
    active = 4'h0;
    step();
    check_model("stop_settle2");
    active = 4'h4;
    step();
    chk("stop_halt_state", int'(state), 3);
    chk("stop_halt_ack", int'(stopAck), 1);
    run = 1'b0; active = 4'h0;
    step();
    check_model("stop_hold");
    stopReq = 1'b0;
    step();
    chk("stop_release_state", int'(state), 0);
    chk("stop_release_ack", int'(stopAck), 0);
    chk("stop_release_cnt", int'(loopCnt), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rstN = ($urandom_range(0, 63) != 0);
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) stopReq = ~stopReq;
      clrOvf = ($urandom_range(0, 15) == 0);
      active = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'h0;
      busy = 4'($urandom_range(0, 15));
      bwOn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
      check_model("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
